// File: rtl/hue_sequencer.sv
// hue_sequencer: walks a six-interval HSV hue wheel and emits registered R/G/B PWM duty words.
// Optional feature macro: HUE_LOAD_EN (adds load / load_interval for a direct interval jump).

module hue_sequencer #(
   parameter int PWM_INTERVAL = 1200,
   parameter int STEP_CYCLES  = 1200,
   parameter int DUTY_STEP    = 1,
   localparam int DW = $clog2(PWM_INTERVAL + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pause,
`ifdef HUE_LOAD_EN
   input  logic          load,
   input  logic [2:0]    load_interval,
`endif
   output logic [DW-1:0] duty_r,
   output logic [DW-1:0] duty_g,
   output logic [DW-1:0] duty_b,
   output logic [2:0]    interval,
   output logic          update
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(STEP_CYCLES - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [DW-1:0] FULL     = DW'(PWM_INTERVAL);
   localparam logic [DW:0]   FULL_W   = (DW + 1)'(PWM_INTERVAL);
   localparam logic [DW:0]   STEP_W   = (DW + 1)'(DUTY_STEP);
   localparam logic [2:0]    LAST_IV  = 3'd5;

   if (DUTY_STEP < 1 || DUTY_STEP > PWM_INTERVAL) begin : g_bad_duty_step
      $error("hue_sequencer: DUTY_STEP must lie in 1..PWM_INTERVAL");
   end

   typedef enum logic [1:0] {
      CH_HIGH = 2'd0,
      CH_LOW  = 2'd1,
      CH_INC  = 2'd2,
      CH_DEC  = 2'd3
   } ch_state_t;

   // Packed {R,G,B} channel states for each 60-degree hue interval.
   function automatic logic [5:0] chan_row(input logic [2:0] iv);
      logic [5:0] row;
      case (iv)
         3'd0:    row = {CH_HIGH, CH_INC,  CH_LOW};
         3'd1:    row = {CH_DEC,  CH_HIGH, CH_LOW};
         3'd2:    row = {CH_LOW,  CH_HIGH, CH_INC};
         3'd3:    row = {CH_LOW,  CH_DEC,  CH_HIGH};
         3'd4:    row = {CH_INC,  CH_LOW,  CH_HIGH};
         3'd5:    row = {CH_HIGH, CH_LOW,  CH_DEC};
         default: row = {CH_HIGH, CH_LOW,  CH_LOW};
      endcase
      return row;
   endfunction

   function automatic logic [DW-1:0] duty_of(input ch_state_t st, input logic [DW-1:0] r);
      logic [DW-1:0] d;
      case (st)
         CH_HIGH: d = FULL;
         CH_LOW:  d = '0;
         CH_INC:  d = r;
         default: d = FULL - r;
      endcase
      return d;
   endfunction

   logic [PW-1:0] prescaler;
   logic [DW-1:0] ramp;

   logic          tick;
   logic          advance;
   logic [PW-1:0] nxt_pre;
   logic [DW-1:0] nxt_ramp;
   logic [2:0]    nxt_interval;
   logic [DW:0]   ramp_sum;
   logic [5:0]    nxt_row;

   always_comb begin
      tick         = (prescaler == PRE_MAX) && !pause;
      ramp_sum     = {1'b0, ramp} + STEP_W;
      advance      = 1'b0;
      nxt_pre      = prescaler;
      nxt_ramp     = ramp;
      nxt_interval = interval;
      if (!pause) begin
         nxt_pre = tick ? '0 : prescaler + PRE_ONE;
      end
      if (tick) begin
         advance = 1'b1;
         // A full ramp is held for one extra tick so each boundary repeats the previous duty.
         if (ramp == FULL) begin
            nxt_ramp     = '0;
            nxt_interval = (interval == LAST_IV) ? 3'd0 : interval + 3'd1;
         end else begin
            nxt_ramp = (ramp_sum > FULL_W) ? FULL : ramp_sum[DW-1:0];
         end
      end
`ifdef HUE_LOAD_EN
      if (load && (load_interval <= LAST_IV)) begin
         advance      = 1'b1;
         nxt_pre      = '0;
         nxt_ramp     = '0;
         nxt_interval = load_interval;
      end
`endif
      nxt_row = chan_row(nxt_interval);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         ramp      <= '0;
         interval  <= 3'd0;
         duty_r    <= FULL;
         duty_g    <= '0;
         duty_b    <= '0;
         update    <= 1'b0;
      end else begin
         prescaler <= nxt_pre;
         ramp      <= nxt_ramp;
         interval  <= nxt_interval;
         duty_r    <= duty_of(ch_state_t'(nxt_row[5:4]), nxt_ramp);
         duty_g    <= duty_of(ch_state_t'(nxt_row[3:2]), nxt_ramp);
         duty_b    <= duty_of(ch_state_t'(nxt_row[1:0]), nxt_ramp);
         update    <= advance;
      end
   end

endmodule

// File: tb/tb_hue_sequencer.sv
// Self-checking bench for hue_sequencer: tick-count reference model plus directed boundary checks.
// Build with +define+HUE_LOAD_EN to also exercise the interval load port.

module tb_hue_sequencer;

   localparam int PI  = 8;
   localparam int SC  = 4;
   localparam int DS  = 3;
   localparam int DW  = $clog2(PI + 1);
   localparam int TPI = (PI + DS - 1) / DS + 1;
   localparam int EW  = 1 + 3 + 3 * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          pause;
`ifdef HUE_LOAD_EN
   logic          load;
   logic [2:0]    load_interval;
`endif
   logic [DW-1:0] duty_r;
   logic [DW-1:0] duty_g;
   logic [DW-1:0] duty_b;
   logic [2:0]    interval;
   logic          update;

   hue_sequencer #(
      .PWM_INTERVAL (PI),
      .STEP_CYCLES  (SC),
      .DUTY_STEP    (DS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pause         (pause),
`ifdef HUE_LOAD_EN
      .load          (load),
      .load_interval (load_interval),
`endif
      .duty_r        (duty_r),
      .duty_g        (duty_g),
      .duty_b        (duty_b),
      .interval      (interval),
      .update        (update)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [EW-1:0] exp_q[$];
   string rows[6] = '{"HIL", "DHL", "LHI", "LDH", "ILH", "HLD"};

   // Reference: count unpaused cycles to find ticks, then derive hue position from the tick count.
   int m_phase = 0;
   int m_ticks = 0;
   int m_start = 0;
   bit m_upd   = 1'b0;
   int exp_iv  = 0;
   int exp_ramp = 0;
   int upd_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_duty(input int iv, input int ch, input int r);
      string s;
      byte c;
      s = rows[iv];
      c = s[ch];
      case (c)
         "H":     return PI;
         "L":     return 0;
         "I":     return r;
         default: return PI - r;
      endcase
   endfunction

   task automatic model_edge();
      bit load_ok;
      load_ok = 1'b0;
`ifdef HUE_LOAD_EN
      load_ok = load && (load_interval <= 3'd5);
`endif
      if (reset) begin
         m_phase = 0; m_ticks = 0; m_start = 0; m_upd = 1'b0;
      end else if (load_ok) begin
`ifdef HUE_LOAD_EN
         m_start = int'(load_interval);
`endif
         m_phase = 0; m_ticks = 0; m_upd = 1'b1;
      end else if (pause) begin
         m_upd = 1'b0;
      end else if (m_phase == SC - 1) begin
         m_phase = 0; m_ticks++; m_upd = 1'b1;
      end else begin
         m_phase++; m_upd = 1'b0;
      end
      exp_iv   = (m_start + m_ticks / TPI) % 6;
      exp_ramp = (m_ticks % TPI) * DS;
      if (exp_ramp > PI) exp_ramp = PI;
   endtask

   // ---------------- driver: one clock, model update, check ----------------
   task automatic cycle();
      logic [EW-1:0] e;
      @(posedge clk);
      model_edge();
      exp_q.push_back({m_upd, 3'(exp_iv), DW'(exp_duty(exp_iv, 0, exp_ramp)),
                       DW'(exp_duty(exp_iv, 1, exp_ramp)), DW'(exp_duty(exp_iv, 2, exp_ramp))});
      #1;
      e = exp_q.pop_front();
      check_eq("update",   32'(update),   32'(e[EW-1]));
      check_eq("interval", 32'(interval), 32'(e[EW-2 -: 3]));
      check_eq("duty_r",   32'(duty_r),   32'(e[3*DW-1 -: DW]));
      check_eq("duty_g",   32'(duty_g),   32'(e[2*DW-1 -: DW]));
      check_eq("duty_b",   32'(duty_b),   32'(e[DW-1 -: DW]));
      if (update) upd_cnt++;
   endtask

   task automatic check_rgb(input string tag, input int r, input int g, input int b);
      check_eq({tag, "_r"}, 32'(duty_r), 32'(r));
      check_eq({tag, "_g"}, 32'(duty_g), 32'(g));
      check_eq({tag, "_b"}, 32'(duty_b), 32'(b));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int iv_seq[$];
      int last_iv;
      int snap_r, snap_g, snap_b, snap_upd;
      bit found;

      reset = 1'b1;
      pause = 1'b0;
`ifdef HUE_LOAD_EN
      load = 1'b0;
      load_interval = 3'd0;
`endif
      repeat (2) cycle();
      check_rgb("reset", PI, 0, 0);
      check_eq("reset_interval", 32'(interval), 0);
      check_eq("reset_update", 32'(update), 0);

      reset = 1'b0;
      upd_cnt = 0;
      repeat (3) cycle();
      check_rgb("idle3", PI, 0, 0);
      check_eq("idle3_updates", 32'(upd_cnt), 0);

      cycle();
      check_eq("c4_duty_g", 32'(duty_g), 3);
      check_eq("c4_update", 32'(update), 1);
      repeat (4) cycle();
      check_eq("c8_duty_g", 32'(duty_g), 6);
      repeat (4) cycle();
      check_eq("c12_duty_g", 32'(duty_g), 8);
      repeat (4) cycle();
      check_eq("c16_interval", 32'(interval), 1);
      check_rgb("c16", PI, PI, 0);
      check_eq("c16_updates", 32'(upd_cnt), 4);

      iv_seq.push_back(0);
      iv_seq.push_back(1);
      last_iv = 1;
      repeat (80) begin
         cycle();
         if (int'(interval) != last_iv) begin
            last_iv = int'(interval);
            iv_seq.push_back(last_iv);
         end
      end
      check_eq("c96_interval", 32'(interval), 0);
      check_rgb("c96", PI, 0, 0);
      check_eq("rotation_updates", 32'(upd_cnt), 24);
      check_eq("iv_seq_len", 32'(iv_seq.size()), 7);
      for (int i = 0; i < iv_seq.size(); i++)
         check_eq("iv_seq", 32'(iv_seq[i]), 32'(i % 6));

      // Pause while the prescaler sits on its last count.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_phase == SC - 1) found = 1'b1;
         else cycle();
      end
      check_eq("pause_seek", 32'(found), 1);
      snap_r = int'(duty_r); snap_g = int'(duty_g); snap_b = int'(duty_b);
      snap_upd = upd_cnt;
      pause = 1'b1;
      repeat (10) cycle();
      check_rgb("paused", snap_r, snap_g, snap_b);
      check_eq("paused_updates", 32'(upd_cnt - snap_upd), 0);
      pause = 1'b0;
      cycle();
      check_eq("unpause_tick", 32'(update), 1);

      // Random pause / occasional reset traffic against the model.
      repeat (300) begin
         pause = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      pause = 1'b0;
      reset = 1'b0;

      // Reset in the middle of interval 3.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (exp_iv == 3 && exp_ramp == 6) found = 1'b1;
         else cycle();
      end
      check_eq("mid_seek", 32'(found), 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check_eq("mid_reset_interval", 32'(interval), 0);
      check_rgb("mid_reset", PI, 0, 0);
      check_eq("mid_reset_update", 32'(update), 0);
      repeat (4) cycle();
      check_eq("post_reset_duty_g", 32'(duty_g), 3);

`ifdef HUE_LOAD_EN
      load = 1'b1;
      load_interval = 3'd4;
      cycle();
      load = 1'b0;
      check_eq("load4_interval", 32'(interval), 4);
      check_rgb("load4", 0, 0, PI);
      check_eq("load4_update", 32'(update), 1);
      cycle();
      check_eq("load4_update_drop", 32'(update), 0);
      snap_r = int'(duty_r); snap_g = int'(duty_g); snap_b = int'(duty_b);
      load = 1'b1;
      load_interval = 3'd7;
      cycle();
      load = 1'b0;
      check_eq("load7_interval", 32'(interval), 4);
      check_rgb("load7", snap_r, snap_g, snap_b);
      check_eq("load7_update", 32'(update), 0);
      repeat (40) begin
         load = ($urandom_range(0, 15) == 0);
         load_interval = 3'($urandom_range(0, 7));
         pause = ($urandom_range(0, 4) == 0);
         cycle();
      end
      load = 1'b0;
      pause = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
